kronos_result_stage: RTL

- Transmit side of the kronos CV-X-IF coprocessor path.
- Issue stage and EX accept and compute instructions; this block returns each finished instruction to the core over the X-IF result channel as {id, rd, data, we}, using a valid/ready handshake.
- Pairs the per-instruction tags captured at issue with EX completions.
- Holds rol32_1 partial results without emitting them.
- Buffers finished results under core backpressure and tells the issue stage when to stop accepting.

---
 rtl/kronos_result_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/kronos_result_stage.sv
// rtl/kronos_result_stage.sv - kronos CV-X-IF result stage: issue-tag pairing, partial hold, result buffering
//
// kronos_result_fifo: a synchronous FIFO whose pointers carry an extra wrap bit.
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write one entry; the caller only pushes when there is room
//   pop              drop the head entry; the caller only pops when not empty
//   head             current head entry (not meaningful while empty)
//   full, empty      occupancy flags
//   count            number of stored entries
//
// kronos_result_stage: returns finished coprocessor instructions to the core.
//   clk_i, rst_i                        clock, synchronous active-high reset
//   save_rd_i, issue_id_i, issue_rd_i   tag capture from the issue stage
//   done_i, continued_i                 EX completion strobe and partial flag
//   result_reg_en_i, ex_result_i        EX result and partial-register load enable
//   partial_o                           held partial result, fed back to EX
//   issue_stall_o                       issue stage must stop accepting
//   result_valid_o, result_ready_i      X-IF result handshake
//   result_id_o, result_rd_o,
//   result_data_o, result_we_o          X-IF result payload, zero while idle
//   err_o                               sticky protocol error

module kronos_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; stale contents are never observed because
    // the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Same slot index but opposite lap: the writer is a full lap ahead.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
endmodule

module kronos_result_stage #(
    parameter int unsigned TAG_DEPTH = 4,
    parameter int unsigned RES_DEPTH = 2,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            save_rd_i,
    input  logic [3:0]      issue_id_i,
    input  logic [4:0]      issue_rd_i,
    input  logic            done_i,
    input  logic            continued_i,
    input  logic            result_reg_en_i,
    input  logic [XLEN-1:0] ex_result_i,
    output logic [XLEN-1:0] partial_o,
    output logic            issue_stall_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [3:0]      result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [XLEN-1:0] result_data_o,
    output logic            result_we_o,
    output logic            err_o
);
    localparam int unsigned TAW    = $clog2(TAG_DEPTH);
    localparam int unsigned RAW    = $clog2(RES_DEPTH);
    localparam int unsigned SW     = ((TAW > RAW) ? TAW : RAW) + 2;
    localparam int unsigned TAG_W  = 4 + 5;
    localparam int unsigned RES_W  = 4 + 5 + XLEN + 1;

    typedef struct packed {
        logic [3:0] id;
        logic [4:0] rd;
    } tag_t;

    typedef struct packed {
        logic [3:0]      id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            we;
    } res_t;

    // Tag queue
    tag_t           tag_in;
    tag_t           tag_head;
    logic           tag_push;
    logic           tag_pop;
    logic           tag_full;
    logic           tag_empty;
    logic [TAW:0]   tag_count;

    // Result queue
    res_t           res_in;
    res_t           res_head;
    logic           res_push;
    logic           res_pop;
    logic           res_full;
    logic           res_empty;
    logic [RAW:0]   res_count;

    logic           final_done;
    logic           partial_done;
    logic           err_event;
    logic [SW-1:0]  occupancy;
    logic [XLEN-1:0] partial_q;
    logic           err_q;

    assign final_done   = done_i && !continued_i;
    assign partial_done = done_i && continued_i;

    // A push into a full tag queue is simply lost; there is no same-cycle
    // pop exception here because issue stalls long before this can happen.
    assign tag_in   = '{id: issue_id_i, rd: issue_rd_i};
    assign tag_push = save_rd_i && !tag_full;
    // Only a tag that was already stored can be paired; a tag arriving in the
    // same cycle is not forwarded to the completion.
    assign tag_pop  = final_done && !tag_empty;

    assign res_pop  = !res_empty && result_ready_i;
    assign res_in   = '{id: tag_head.id, rd: tag_head.rd, data: ex_result_i, we: 1'b1};
    // A full result queue still takes the entry when its head leaves this cycle.
    assign res_push = tag_pop && (!res_full || res_pop);

    kronos_result_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (tag_push),
        .push_data (tag_in),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    kronos_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (res_push),
        .push_data (res_in),
        .pop       (res_pop),
        .head      (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    // Partial register for the first half of a rol32 pair; only a partial
    // completion may load it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            partial_q <= '0;
        end else if (partial_done && result_reg_en_i) begin
            partial_q <= ex_result_i;
        end
    end

    assign err_event = (save_rd_i && tag_full)
                     || (final_done && tag_empty)
                     || (tag_pop && res_full && !res_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    // Reserve a result slot for every instruction in flight: EX cannot be
    // stalled, so issue must stop before outstanding work exceeds the buffer.
    assign occupancy     = SW'(tag_count) + SW'(res_count);
    assign issue_stall_o = (occupancy >= SW'(RES_DEPTH)) || tag_full;

    assign partial_o      = partial_q;
    assign err_o          = err_q;
    assign result_valid_o = !res_empty;
    assign result_id_o    = res_empty ? '0 : res_head.id;
    assign result_rd_o    = res_empty ? '0 : res_head.rd;
    assign result_data_o  = res_empty ? '0 : res_head.data;
    assign result_we_o    = res_empty ? 1'b0 : res_head.we;
endmodule
